// File: rtl/spi_gen_pkg.sv
// Shared types for the generic SPI slave: gray-coded FSM states and frame command codes.
package spi_gen_pkg;

  // Adjacent states differ in one bit along the main frame path.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_CHK_CMD   = 3'b001,
    ST_WRITE     = 3'b011,
    ST_READ_ADD  = 3'b010,
    ST_READ_DATA = 3'b110,
    ST_WAIT_TX   = 3'b111,
    ST_SEND      = 3'b101,
    ST_DONE      = 3'b100
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_gen_if.sv
// Bus bundle between the SPI slave and its master/memory side.
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              frame_err;

  // Handshake: rx_valid and frame_err are one-cycle pulses with no back-pressure;
  // tx_valid has no ready partner, it is accepted only on a cycle spent waiting for read data.
  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-load, MSB-first serialiser for read data; o_done flags the cycle after the last bit.
module spi_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_abort,
  output logic              o_serial,
  output logic              o_done
);
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_active;
  logic              r_serial;

  always_ff @(posedge clk) begin
    if (!rst_n || i_abort) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_serial <= 1'b0;
    end else if (i_load) begin
      // MSB goes straight to the output register; the rest waits in the shifter.
      r_shift  <= i_data << 1;
      r_serial <= i_data[DATA_W-1];
      r_cnt    <= CW'(1);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == CW'(DATA_W)) begin
        r_serial <= 1'b0;
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_serial <= r_shift[DATA_W-1];
        r_shift  <= r_shift << 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign o_serial = r_serial;
  assign o_done   = r_active && (r_cnt == CW'(DATA_W));
endmodule

// File: rtl/spi_slave_gen.sv
// Generic SPI slave: decodes 2-bit command frames, returns read data after a read-address frame.
module spi_slave_gen
  import spi_gen_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_gen_if.slave  bus,
  output state_e          o_state
);
  localparam int N  = DATA_W + 2;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);

  state_e        r_state;
  logic [CW-1:0] r_bit_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [N-1:0]  r_rx_data;
  logic          r_rx_valid;
  logic          r_frame_err;
  logic          r_rd_addr_seen;

  logic w_load;
  logic w_tx_abort;
  logic w_miso;
  logic w_tx_done;

  assign w_load     = (r_state == ST_WAIT_TX) && !bus.SS_n && bus.tx_valid;
  assign w_tx_abort = (r_state == ST_SEND) && bus.SS_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_bit_cnt      <= '0;
      r_to_cnt       <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!bus.SS_n) begin
            r_state   <= ST_CHK_CMD;
            r_bit_cnt <= '0;
          end
        end
        ST_CHK_CMD: begin
          if (bus.SS_n) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_rx_data <= {r_rx_data[N-2:0], bus.MOSI};
            r_bit_cnt <= CW'(1);
            if (!bus.MOSI)          r_state <= ST_WRITE;
            else if (r_rd_addr_seen) r_state <= ST_READ_DATA;
            else                    r_state <= ST_READ_ADD;
          end
        end
        ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
          // All N bits are in once the counter reaches N; this cycle only reports.
          if (r_bit_cnt == CW'(N)) begin
            r_rx_valid <= 1'b1;
            if (r_state == ST_READ_DATA) begin
              r_rd_addr_seen <= 1'b0;
              r_to_cnt       <= '0;
              r_state        <= ST_WAIT_TX;
            end else begin
              if (r_state == ST_READ_ADD) r_rd_addr_seen <= 1'b1;
              r_state <= ST_DONE;
            end
          end else if (bus.SS_n) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_rx_data <= {r_rx_data[N-2:0], bus.MOSI};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_WAIT_TX: begin
          if (bus.SS_n) begin
            r_state <= ST_IDLE;
          end else if (bus.tx_valid) begin
            r_state <= ST_SEND;
          end else if (r_to_cnt == TW'(TX_TIMEOUT - 1)) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.SS_n)      r_state <= ST_IDLE;
          else if (w_tx_done) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.SS_n) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  spi_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_tx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_data   (bus.tx_data),
    .i_abort  (w_tx_abort),
    .o_serial (w_miso),
    .o_done   (w_tx_done)
  );

  assign bus.MISO      = w_miso;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign o_state       = r_state;
endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed and randomized frames against a frame-level model of the SPI slave (8- and 16-bit builds).
module tb_spi_slave_gen;
  import spi_gen_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_W(8))  bus8();
  spi_slave_gen_if #(.DATA_W(16)) bus16();
  state_e state8;
  state_e state16;

  spi_slave_gen #(.DATA_W(8), .TX_TIMEOUT(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .o_state(state8)
  );
  spi_slave_gen #(.DATA_W(16), .TX_TIMEOUT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16), .o_state(state16)
  );

  int errors = 0;
  int checks = 0;
  bit m_seen = 1'b0;
  logic [9:0] exp_q[$];
  logic [0:0] miso_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // tx_lat < 0 means tx_valid is never raised for a read-data frame.
  task automatic run_frame(input logic [9:0] frame, input int tx_lat, input logic [7:0] txd);
    state_e exp_st;
    logic [9:0] exp_rx;
    if (!frame[9])   exp_st = ST_WRITE;
    else if (m_seen) exp_st = ST_READ_DATA;
    else             exp_st = ST_READ_ADD;
    exp_q.push_back(frame);
    bus8.SS_n = 1'b0;
    tick;
    check("enter_chk", state8, ST_CHK_CMD);
    for (int j = 1; j <= 10; j++) begin
      bus8.MOSI = frame[10-j];
      tick;
      if (j == 1) check("decode", state8, exp_st);
      check("rx_valid_early", bus8.rx_valid, 1'b0);
      check("miso_rx", bus8.MISO, 1'b0);
    end
    bus8.MOSI = 1'($urandom);
    tick;
    exp_rx = exp_q.pop_front();
    check("rx_valid", bus8.rx_valid, 1'b1);
    check("rx_data", bus8.rx_data, exp_rx);
    check("miso_end_rx", bus8.MISO, 1'b0);
    if (exp_st == ST_READ_ADD)  m_seen = 1'b1;
    if (exp_st == ST_READ_DATA) m_seen = 1'b0;
    if (exp_st == ST_READ_DATA) begin
      check("wait_state", state8, ST_WAIT_TX);
      if (tx_lat < 0) begin
        for (int k = 1; k <= 16; k++) begin
          tick;
          check("timeout_err", bus8.frame_err, (k == 16) ? 32'd1 : 32'd0);
          check("miso_wait", bus8.MISO, 1'b0);
        end
        tick;
        check("timeout_pulse", bus8.frame_err, 1'b0);
        check("timeout_done", state8, ST_DONE);
      end else begin
        for (int k = 0; k < tx_lat; k++) begin
          tick;
          check("wait_err", bus8.frame_err, 1'b0);
          check("miso_wait", bus8.MISO, 1'b0);
        end
        bus8.tx_data  = txd;
        bus8.tx_valid = 1'b1;
        for (int b = 7; b >= 0; b--) miso_q.push_back(txd[b]);
        for (int b = 0; b < 8; b++) begin
          tick;
          bus8.tx_valid = 1'b0;
          bus8.tx_data  = 8'($urandom);
          check("miso_bit", bus8.MISO, miso_q.pop_front());
        end
        tick;
        check("miso_after_send", bus8.MISO, 1'b0);
        check("send_done", state8, ST_DONE);
      end
    end else begin
      tick;
      check("rx_valid_pulse", bus8.rx_valid, 1'b0);
      check("frame_done", state8, ST_DONE);
    end
    for (int k = 0; k < 2; k++) begin
      bus8.MOSI = 1'($urandom);
      tick;
      check("done_hold", state8, ST_DONE);
      check("done_no_rx", bus8.rx_valid, 1'b0);
    end
    bus8.SS_n = 1'b1;
    tick;
    check("back_idle", state8, ST_IDLE);
  endtask

  initial begin
    logic [9:0]  f10;
    logic [17:0] f16;
    bus8.SS_n = 1'b1;  bus8.MOSI = 1'b0;  bus8.tx_data = '0;  bus8.tx_valid = 1'b0;
    bus16.SS_n = 1'b1; bus16.MOSI = 1'b0; bus16.tx_data = '0; bus16.tx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick;
    check("rst_miso", bus8.MISO, 1'b0);
    check("rst_rx_valid", bus8.rx_valid, 1'b0);
    check("rst_frame_err", bus8.frame_err, 1'b0);
    check("rst_rx_data", bus8.rx_data, 10'h000);
    check("rst_state", state8, ST_IDLE);
    check("rst_rx_data16", bus16.rx_data, 18'h00000);
    rst_n = 1'b1;
    tick;
    check("idle_hold", state8, ST_IDLE);

    // Plain write frame.
    run_frame(10'b00_1010_0101, 0, 8'h00);
    // Read address then read data returning C3.
    run_frame(10'b10_0000_0011, 0, 8'h00);
    run_frame(10'b11_0101_1010, 0, 8'hC3);

    // Write frame aborted after 5 bits.
    f10 = 10'b00_1010_0101;
    bus8.SS_n = 1'b0;
    tick;
    for (int j = 1; j <= 5; j++) begin
      bus8.MOSI = f10[10-j];
      tick;
    end
    bus8.SS_n = 1'b1;
    tick;
    check("abort_err", bus8.frame_err, 1'b1);
    check("abort_rx_valid", bus8.rx_valid, 1'b0);
    check("abort_state", state8, ST_IDLE);
    tick;
    check("abort_err_pulse", bus8.frame_err, 1'b0);
    check("abort_rx_valid2", bus8.rx_valid, 1'b0);

    // Read address, aborted read-data frame keeps the address flag, then a timeout.
    run_frame(10'b10_1111_0000, 0, 8'h00);
    bus8.SS_n = 1'b0;
    tick;
    for (int j = 1; j <= 3; j++) begin
      bus8.MOSI = 1'b1;
      tick;
    end
    bus8.SS_n = 1'b1;
    tick;
    check("abort_rd_err", bus8.frame_err, 1'b1);
    tick;
    run_frame(10'b11_0000_0000, -1, 8'h00);

    // Reset while read data is being shifted out.
    run_frame(10'b10_0001_0001, 0, 8'h00);
    bus8.SS_n = 1'b0;
    tick;
    for (int j = 1; j <= 10; j++) begin
      bus8.MOSI = 1'b1;
      tick;
    end
    tick;
    check("rst_send_rx", bus8.rx_valid, 1'b1);
    bus8.tx_data  = 8'h5A;
    bus8.tx_valid = 1'b1;
    tick;
    bus8.tx_valid = 1'b0;
    check("rst_send_b7", bus8.MISO, 1'b0);
    tick;
    check("rst_send_b6", bus8.MISO, 1'b1);
    tick;
    check("rst_send_b5", bus8.MISO, 1'b0);
    tick;
    check("rst_send_b4", bus8.MISO, 1'b1);
    rst_n = 1'b0;
    tick;
    check("rst_send_miso", bus8.MISO, 1'b0);
    check("rst_send_rx_valid", bus8.rx_valid, 1'b0);
    check("rst_send_err", bus8.frame_err, 1'b0);
    check("rst_send_state", state8, ST_IDLE);
    m_seen = 1'b0;
    rst_n = 1'b1;
    bus8.SS_n = 1'b1;
    tick;
    run_frame(10'b11_1100_0011, 0, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      int lat;
      lat = ($urandom_range(0, 7) == 7) ? -1 : int'($urandom_range(0, 6));
      run_frame(10'($urandom), lat, 8'($urandom));
    end

    // 16-bit payload build.
    f16 = {2'b01, 16'($urandom)};
    bus16.SS_n = 1'b0;
    tick;
    for (int j = 1; j <= 18; j++) begin
      bus16.MOSI = f16[18-j];
      tick;
      check("w16_rx_valid_early", bus16.rx_valid, 1'b0);
    end
    tick;
    check("w16_rx_valid", bus16.rx_valid, 1'b1);
    check("w16_rx_data", bus16.rx_data, f16);
    check("w16_miso", bus16.MISO, 1'b0);
    bus16.SS_n = 1'b1;
    tick;
    tick;
    check("w16_idle", state16, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_gen.md
SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame; frame length N = DATA_W+2 (2 command bits + payload).
REQ-002 Parameter TX_TIMEOUT, default 16: maximum clk cycles spent waiting for tx_valid after a read-data frame.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 SS_n  input  1  slave select, active-low; high = bus idle.
REQ-006 MOSI  input  1  serial data in, sampled every clk while selected, MSB first.
REQ-007 MISO  output  1  serial data out, registered, MSB first.
REQ-008 rx_data  output  N  received frame {cmd[1:0], payload[DATA_W-1:0]}.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data holds a complete frame.
REQ-010 tx_data  input  DATA_W  read data from memory side.
REQ-011 tx_valid  input  1  tx_data valid; sampled only in state WAIT_TX.
REQ-012 frame_err  output  1  one-cycle pulse: aborted frame or tx timeout.

Function
REQ-013 States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
REQ-014 IDLE -> CHK_CMD on the first cycle SS_n = 0; otherwise stays in IDLE.
REQ-015 CHK_CMD samples frame bit 0 (cmd[1]) from MOSI and shifts it into rx_data; MOSI=0 -> WRITE; MOSI=1 with rd_addr_seen=0 -> READ_ADD; MOSI=1 with rd_addr_seen=1 -> READ_DATA.
REQ-016 WRITE/READ_ADD/READ_DATA shift the remaining N-1 bits into rx_data LSB-first position ({rx_data[N-2:0], MOSI}), one bit per clk.
REQ-017 The bit counter counts frame bits 0..N-1; the cycle after bit N-1 is sampled, rx_valid = 1 for exactly one cycle.
REQ-018 Latency: rx_valid asserts N+1 cycles after SS_n is first sampled low.
REQ-019 End of WRITE or READ_ADD frame -> DONE; READ_ADD completion sets rd_addr_seen = 1.
REQ-020 End of READ_DATA frame -> WAIT_TX; rd_addr_seen is cleared.
REQ-021 WAIT_TX: tx_valid = 1 loads tx_data into the tx shifter -> SEND; after TX_TIMEOUT cycles without tx_valid -> frame_err pulse, then DONE.
REQ-022 SEND drives tx_data MSB first on MISO, one bit per clk, DATA_W bits, the first bit on the cycle after the load; then DONE.
REQ-023 MISO = 0 in every state other than SEND.
REQ-024 DONE holds until SS_n = 1, then IDLE; extra MOSI bits are ignored.
REQ-025 SS_n = 1 in CHK_CMD/WRITE/READ_ADD/READ_DATA before bit N-1: frame_err pulse, no rx_valid, rd_addr_seen unchanged, -> IDLE.
REQ-026 SS_n = 1 in WAIT_TX or SEND: no frame_err, MISO = 0 next cycle, -> IDLE; the remaining read data is discarded.
REQ-027 rx_data holds its last value outside shifting states; it is not cleared in IDLE.
REQ-028 The bit counter is $clog2(N+1) bits wide and cleared on every entry to CHK_CMD; the timeout counter is $clog2(TX_TIMEOUT+1) bits wide.

Reset
REQ-029 rst_n = 0 at a clk edge: state = IDLE, MISO = 0, rx_valid = 0, frame_err = 0, rx_data = 0, rd_addr_seen = 0, counters = 0.
REQ-030 Reset mid-frame has priority over all transitions, and no rx_valid or frame_err is issued for the interrupted frame.

Structure
REQ-031 Package spi_gen_pkg holds the state enum (gray-encoded) and command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
REQ-032 Sub-module spi_tx_shifter (parallel load, MSB-first serial out, done flag) implements SEND; the rest stays in spi_slave_gen.

Verification (DATA_W=8)
REQ-033 Write frame 00_1010_0101 -> rx_data = 10'h0A5, one rx_valid pulse at cycle 11, MISO = 0 throughout.
REQ-034 Read-addr frame 10_0000_0011, SS_n high, then read-data frame 11_xxxx_xxxx with tx_valid=1, tx_data=8'hC3 -> MISO = 1,1,0,0,0,0,1,1.
REQ-035 SS_n raised after 5 bits of a write frame -> frame_err pulse, no rx_valid, state IDLE.
REQ-036 Read-data frame with tx_valid held low -> frame_err after 16 cycles in WAIT_TX, MISO = 0.
REQ-037 rst_n low during SEND bit 3 -> MISO = 0, rx_valid = 0 next cycle; next frame decodes as READ_ADD.
REQ-038 DATA_W=16 build: write frame of 18 bits -> rx_valid at cycle 19 with the correct rx_data.
